tpu_seq_ctrl: RTL and testbench
===============================

Name: tpu_seq_ctrl

Overview:
Top-level run sequencer for the TPU datapath, directly downstream of the APB configuration register block. It consumes start_tpu and the four stage enables, then runs the enabled stages in fixed order: matmul -> norm -> pool -> activation. Each stage gets a start handshake, and the block waits for that stage's done before moving on. At the end it drives done_tpu (plus an error flag and a cycle count) back to the register block for software polling.

Parameters:
CNT_WIDTH, 32, width of busy_cycles performance counter
TIMEOUT_CYCLES, 65535, max cycles allowed in one stage before abort; 0 disables timeout
TO_WIDTH, 16, width of per-stage timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-high reset
start_tpu  input  1  run request level from config block
enable_matmul  input  1  stage enable
enable_norm  input  1  stage enable
enable_pool  input  1  stage enable
enable_activation  input  1  stage enable
done_mat_mul  input  1  matmul stage complete
done_norm  input  1  norm stage complete
done_pool  input  1  pool stage complete
done_activation  input  1  activation stage complete
start_mat_mul  output  1  matmul stage run (level)
start_norm  output  1  norm stage run (level)
start_pool  output  1  pool stage run (level)
start_activation  output  1  activation stage run (level)
done_tpu  output  1  run finished, to config block
tpu_error  output  1  last run aborted by timeout
busy_cycles  output  CNT_WIDTH  cycles spent in stage states during last/current run
state_o  output  3  current FSM state, debug

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; start_q=0; latched enables=0; every output 0, including busy_cycles and tpu_error.
- FSM states and encodings: IDLE=0, MATMUL=1, NORM=2, POOL=3, ACT=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE next cycle.
- Start detection: start_q registers start_tpu every cycle. A run begins in IDLE when start_tpu=1 and start_q=0 (rising edge).
  - Because start_q resets to 0, a start_tpu held high through reset starts a run on the first cycle after reset.
  - start_tpu=1 while not in IDLE is ignored.
- On a run start:
  - Latch all four enables into internal registers; enable changes later in the run are ignored.
  - Clear busy_cycles and tpu_error.
  - Next state is the first enabled stage in order. If no stage is enabled, go directly to DONE.
- Stage states:
  - The matching start_* output is 1 for every cycle the FSM is in that state; all other start_* are 0. Outputs decode from the registered state, so start_* rises the cycle after the start edge is sampled.
  - The matching done_* input is sampled each cycle. When it is 1, the next state is the next enabled stage in order, or DONE if none remain. start_* therefore drops the cycle after done is sampled.
  - A done for the current stage sampled in the same cycle the state is entered counts immediately, giving a minimum of 1 cycle per stage.
  - done_* for non-current stages is ignored.
- Timeout:
  - The per-stage counter clears on every state change and increments in stage states.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without done, go to DONE and set tpu_error=1.
  - If done and timeout occur in the same cycle, done wins: normal advance, no error.
- busy_cycles increments by 1 every cycle in MATMUL/NORM/POOL/ACT, saturates at all-ones, and holds its value in DONE and IDLE.
- DONE:
  - done_tpu=1 while in DONE.
  - Leave DONE for IDLE when start_tpu=0 (software clears start). done_tpu drops the cycle the FSM is back in IDLE.
  - A new run requires a fresh start_tpu rising edge in IDLE.
- tpu_error holds until the next run start or reset.
- Reset mid-run: immediate return to the reset state; all start_* deassert on the next cycle. Downstream stages must tolerate start dropping without done.

Test Plan:
- All four enables=1; start_tpu 0->1 at cycle 10; each done_* pulsed 5 cycles after its start rises -> starts assert in order; done_tpu=1 at cycle ~35; busy_cycles=24; tpu_error=0.
- enable_matmul=1, enable_pool=1 only -> start_norm and start_activation never assert; FSM goes MATMUL->POOL->DONE; state_o sequence 1,3,5.
- Enables all 0, start edge -> DONE next cycle; done_tpu=1; busy_cycles=0; start_tpu 1->0 -> IDLE; done_tpu=0 the following cycle.
- TIMEOUT_CYCLES=8, done_mat_mul never asserted -> after 8 cycles in MATMUL: DONE, tpu_error=1. Next start edge clears tpu_error. Repeat with done_mat_mul asserted exactly at count 8 -> no error, advance.
- Toggle enable_norm and assert spurious done_pool during MATMUL -> no effect on sequence. start_tpu held high through DONE -> FSM stays in DONE with no restart.
- Assert reset during NORM -> next cycle all outputs 0 and state_o=0. start_tpu held at 1 across reset release -> new run starts in MATMUL (if enabled) one cycle later.

Source files
------------

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl -- run sequencer for the TPU datapath.
//
// Waits for a rising edge of start_tpu in IDLE, latches the four stage
// enables, then runs the enabled stages in the fixed order
// matmul -> norm -> pool -> activation. Each stage sees a level start_*
// for as long as the FSM sits in its state and is left when that stage's
// done_* is sampled high. A per-stage timeout aborts the run into DONE with
// tpu_error set. done_tpu is held in DONE until software drops start_tpu.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   start_tpu               run request level from the config block
//   enable_*                stage enables, latched at run start
//   done_*                  per-stage completion, sampled in the stage state
//   start_*                 per-stage run level, decoded from the state register
//   done_tpu                high while in DONE
//   tpu_error               last run aborted by timeout
//   busy_cycles             saturating count of stage-state cycles this run
//   state_o                 FSM state code (debug)
//
// A stage lasts at most TIMEOUT_CYCLES cycles: the stage is aborted in the
// cycle where the per-stage counter would reach TIMEOUT_CYCLES, unless its
// done is sampled in that same cycle.

module tpu_seq_ctrl #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_tpu,
    input  logic                 enable_matmul,
    input  logic                 enable_norm,
    input  logic                 enable_pool,
    input  logic                 enable_activation,
    input  logic                 done_mat_mul,
    input  logic                 done_norm,
    input  logic                 done_pool,
    input  logic                 done_activation,
    output logic                 start_mat_mul,
    output logic                 start_norm,
    output logic                 start_pool,
    output logic                 start_activation,
    output logic                 done_tpu,
    output logic                 tpu_error,
    output logic [CNT_WIDTH-1:0] busy_cycles,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MATMUL = 3'd1,
        S_NORM   = 3'd2,
        S_POOL   = 3'd3,
        S_ACT    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state, state_nx;
    logic                start_q;
    logic [3:0]          en_q;        // bit0 matmul .. bit3 activation
    logic [TO_WIDTH-1:0] to_cnt;
    logic                run_start;
    logic                in_stage;
    logic                stage_done;
    logic                timeout;
    logic                set_err;

    // First enabled stage whose index is >= from_idx, else DONE. Stage index
    // i maps to state code i+1, so passing a stage's own state code as
    // from_idx yields the stage that follows it.
    function automatic state_t first_from(input logic [3:0] en, input logic [2:0] from_idx);
        state_t r;
        r = S_DONE;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from_idx) && en[i]) r = state_t'(3'(i + 1));
        end
        return r;
    endfunction

    assign run_start = (state == S_IDLE) && start_tpu && !start_q;
    assign in_stage  = (state == S_MATMUL) || (state == S_NORM) ||
                       (state == S_POOL)   || (state == S_ACT);

    // Only the current stage's done is looked at; the others are ignored.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        stage_done = 1'b0;
        case (state)
            S_MATMUL: stage_done = done_mat_mul;
            S_NORM:   stage_done = done_norm;
            S_POOL:   stage_done = done_pool;
            S_ACT:    stage_done = done_activation;
            default:  stage_done = 1'b0;
        endcase
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && in_stage &&
                     (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_start)
                    state_nx = first_from({enable_activation, enable_pool,
                                           enable_norm, enable_matmul}, 3'd0);
            end
            S_MATMUL, S_NORM, S_POOL, S_ACT: begin
                // done wins over a timeout in the same cycle
                if (stage_done) begin
                    state_nx = first_from(en_q, state);
                end else if (timeout) begin
                    state_nx = S_DONE;
                    set_err  = 1'b1;
                end
            end
            S_DONE: begin
                if (!start_tpu) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;   // illegal codes 6/7 recover
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            en_q        <= 4'b0;
            to_cnt      <= '0;
            busy_cycles <= '0;
            tpu_error   <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start_tpu;

            if (run_start)
                en_q <= {enable_activation, enable_pool, enable_norm, enable_matmul};

            if (state_nx != state || !in_stage)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_WIDTH'(1);

            if (run_start)
                busy_cycles <= '0;
            else if (in_stage && busy_cycles != {CNT_WIDTH{1'b1}})
                busy_cycles <= busy_cycles + CNT_WIDTH'(1);

            if (run_start)
                tpu_error <= 1'b0;
            else if (set_err)
                tpu_error <= 1'b1;
        end
    end

    assign start_mat_mul    = (state == S_MATMUL);
    assign start_norm       = (state == S_NORM);
    assign start_pool       = (state == S_POOL);
    assign start_activation = (state == S_ACT);
    assign done_tpu         = (state == S_DONE);
    assign state_o          = state;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl -- self-checking bench for tpu_seq_ctrl.
//
// Each run is described by its enables and, per stage, the number of cycles
// after stage entry at which that stage's done is raised. The expected
// trace (stage order, stage length, busy count, error) is derived from those
// numbers; the bench then plays the run cycle by cycle and checks the DUT
// outputs on every falling edge. Inputs are driven on the falling edge too.

module tb_tpu_seq_ctrl;

    localparam int CNT_W   = 5;     // small so the busy counter saturates
    localparam int TO      = 8;
    localparam int TO_W    = 4;
    localparam int BUSY_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_tpu;
    logic [3:0]       en_drv;
    logic [3:0]       dn_drv;
    logic             start_mat_mul, start_norm, start_pool, start_activation;
    logic             done_tpu, tpu_error;
    logic [CNT_W-1:0] busy_cycles;
    logic [2:0]       state_o;

    int tests  = 0;
    int failed = 0;
    int dly[4];

    tpu_seq_ctrl #(
        .CNT_WIDTH      (CNT_W),
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (TO_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_tpu         (start_tpu),
        .enable_matmul     (en_drv[0]),
        .enable_norm       (en_drv[1]),
        .enable_pool       (en_drv[2]),
        .enable_activation (en_drv[3]),
        .done_mat_mul      (dn_drv[0]),
        .done_norm         (dn_drv[1]),
        .done_pool         (dn_drv[2]),
        .done_activation   (dn_drv[3]),
        .start_mat_mul     (start_mat_mul),
        .start_norm        (start_norm),
        .start_pool        (start_pool),
        .start_activation  (start_activation),
        .done_tpu          (done_tpu),
        .tpu_error         (tpu_error),
        .busy_cycles       (busy_cycles),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > BUSY_MAX) ? BUSY_MAX : x;
    endfunction

    // Compare every output against the expected state code, busy count, error.
    task automatic check_cycle(input string tag, input int st, input int busy, input bit err);
        int exp_starts;
        exp_starts = (st >= 1 && st <= 4) ? (1 << (st - 1)) : 0;
        check({tag, ":state"},    32'(state_o), 32'(st));
        check({tag, ":start"},    32'({start_activation, start_pool, start_norm, start_mat_mul}),
                                  32'(exp_starts));
        check({tag, ":done_tpu"}, 32'(done_tpu), 32'(st == 5));
        check({tag, ":busy"},     32'(busy_cycles), 32'(sat(busy)));
        check({tag, ":err"},      32'(tpu_error), 32'(err));
    endtask

    // Precondition: at a falling edge, DUT idle, start_tpu low last edge.
    // chaos randomises ignored inputs (enables mid-run, other stages' done,
    // start_tpu during stages, start_tpu held high in DONE).
    task automatic do_run(input string tag, input logic [3:0] en, input bit chaos);
        int  busy = 0;
        bit  err  = 1'b0;
        int  dur;
        int  hold;
        en_drv    = en;
        dn_drv    = 4'b0;
        start_tpu = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            if (!en[s] || err) continue;
            dur = (dly[s] + 1 <= TO) ? dly[s] + 1 : TO;
            for (int k = 0; k < dur; k++) begin
                check_cycle({tag, ":stage"}, s + 1, busy, 1'b0);
                dn_drv = chaos ? 4'($urandom_range(0, 15)) : 4'b0;
                dn_drv[s] = (k == dly[s]);
                if (chaos) begin
                    en_drv    = 4'($urandom_range(0, 15));
                    start_tpu = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                busy++;
            end
            if (dly[s] + 1 > TO) err = 1'b1;
        end
        dn_drv = 4'b0;
        check_cycle({tag, ":done"}, 5, busy, err);
        hold = chaos ? $urandom_range(0, 3) : 0;
        for (int h = 0; h < hold; h++) begin
            start_tpu = 1'b1;
            @(negedge clk);
            check_cycle({tag, ":hold"}, 5, busy, err);
        end
        start_tpu = 1'b0;
        @(negedge clk);
        check_cycle({tag, ":idle"}, 0, busy, err);
    endtask

    initial begin
        reset     = 1'b1;
        start_tpu = 1'b0;
        en_drv    = 4'b0;
        dn_drv    = 4'b0;
        repeat (3) @(negedge clk);
        check_cycle("reset", 0, 0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_cycle("post_reset", 0, 0, 1'b0);

        // All stages, done 5 cycles after each start rises: 4 x 6 cycles.
        dly = '{5, 5, 5, 5};
        do_run("all_en", 4'b1111, 1'b0);
        check("all_en:busy24", 32'(busy_cycles), 32'(sat(24)));

        // Matmul and pool only.
        dly = '{1, 3, 2, 4};
        do_run("mm_pool", 4'b0101, 1'b0);

        // Nothing enabled: straight to DONE, busy stays 0.
        do_run("none", 4'b0000, 1'b0);

        // Matmul never completes: timeout after TO cycles.
        dly = '{100, 0, 0, 0};
        do_run("timeout", 4'b0001, 1'b0);

        // Done exactly in the last allowed cycle: no error, and the new run
        // start has cleared the previous error.
        dly = '{TO - 1, 2, 0, 0};
        do_run("edge_ok", 4'b0011, 1'b0);

        // Leave an error behind, then reset mid-run in NORM with start held.
        dly = '{100, 0, 0, 0};
        do_run("timeout2", 4'b0001, 1'b0);
        en_drv    = 4'b1111;
        start_tpu = 1'b1;
        @(negedge clk);
        check_cycle("rst:mm", 1, 0, 1'b0);
        dn_drv = 4'b0001;
        @(negedge clk);
        dn_drv = 4'b0000;
        check_cycle("rst:norm", 2, 1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_cycle("rst:asserted", 0, 0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_cycle("rst:restart", 1, 0, 1'b0);
        reset     = 1'b1;
        start_tpu = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cycle("rst:clean", 0, 0, 1'b0);

        // Randomised runs with noise on all ignored inputs.
        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < 4; s++) dly[s] = $urandom_range(0, 9);
            do_run($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
